// File: rtl/imem_loader_pkg.sv
// Shared CPU package: CPU-wide word/address typedefs, loader state encoding,
// and a helper that maps each loader state to its status outputs.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CSUM state).
package imem_loader_pkg;

  typedef logic [31:0] cpu_word_t;
  typedef logic [31:0] cpu_addr_t;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } imem_ld_state_e;

  typedef struct packed {
    logic ready;
    logic hold;
    logic done;
    logic err;
  } ld_flags_t;

  // Status outputs are a pure function of the state being entered, so the
  // FSM can register them alongside the state itself.
  function automatic ld_flags_t state_flags(imem_ld_state_e s);
    ld_flags_t f;
    f.ready = (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.ready = f.ready || (s == ST_CSUM);
`endif
    f.hold  = (s != ST_DONE);
    f.done  = (s == ST_DONE);
    f.err   = (s == ST_ERR);
    return f;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Byte-to-word packer: shifts accepted bytes MSB first and flags the byte
// that completes a 4-byte word. The completing byte is combined directly
// into o_word so the word is usable on the same edge it completes.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_shift,
  input  logic [7:0] i_byte,
  output cpu_word_t  o_word,
  output logic       o_word_done
);

  logic [23:0] r_sr;
  logic [1:0]  r_cnt;

  assign o_word      = {r_sr, i_byte};
  assign o_word_done = i_shift && (r_cnt == 2'(WORD_BYTES - 1));

  // Shift register and byte counter advance only on accepted DATA bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr  <= {r_sr[15:0], i_byte};
      r_cnt <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a byte stream (16-bit word count,
// then words MSB first), writes the words to instruction memory and holds
// the CPU until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum).
//
// state | meaning
// HDR0  | waiting for word count high byte
// HDR1  | waiting for word count low byte
// DATA  | packing data bytes into words and writing them
// CSUM  | waiting for checksum byte (checksum build only)
// FLUSH | one cycle after the final write
// DONE  | image loaded, CPU released (terminal)
// ERR   | load failed, CPU held (terminal)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] LP_MAX = 32'(MAX_WORDS);

  imem_ld_state_e r_state;
  imem_ld_state_e w_state_nxt;
  ld_flags_t      w_flags;

  logic [7:0]  r_hdr_hi;
  logic [15:0] r_word_cnt;
  logic [15:0] r_word_idx;
  cpu_addr_t   r_addr_nxt;

  logic        w_accept;
  logic        w_shift;
  logic        w_word_done;
  logic        w_last_word;
  logic [15:0] w_n;
  cpu_word_t   w_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  assign w_accept    = byte_valid && byte_ready;
  assign w_shift     = w_accept && (r_state == ST_DATA);
  assign w_n         = {r_hdr_hi, byte_data};
  // Word count is at least 1 whenever DATA is active, so no underflow here.
  assign w_last_word = (r_word_idx == (r_word_cnt - 16'd1));
  assign w_flags     = state_flags(w_state_nxt);

  imem_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_shift     (w_shift),
    .i_byte      (byte_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  // Next-state decision; DONE and ERR fall through to hold forever.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HDR0: if (w_accept) w_state_nxt = ST_HDR1;
      ST_HDR1: begin
        if (w_accept) begin
          if ({16'd0, w_n} > LP_MAX) w_state_nxt = ST_ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
          else if (w_n == 16'd0) w_state_nxt = ST_CSUM;
`else
          else if (w_n == 16'd0) w_state_nxt = ST_DONE;
`endif
          else w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_done && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_nxt = ST_CSUM;
`else
          w_state_nxt = ST_FLUSH;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: if (w_accept) w_state_nxt = (byte_data == r_xor) ? ST_FLUSH : ST_ERR;
`endif
      ST_FLUSH: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      ST_ERR:   w_state_nxt = ST_ERR;
      default:  w_state_nxt = ST_ERR;
    endcase
  end

  // State register with status outputs registered from the entered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HDR0;
      byte_ready <= 1'b1;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      byte_ready <= w_flags.ready;
      cpu_hold   <= w_flags.hold;
      done       <= w_flags.done;
      error      <= w_flags.err;
    end
  end

  // Header capture, word counter and memory write port; reset drops any
  // write strobe that was about to be issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_hi   <= '0;
      r_word_cnt <= '0;
      r_word_idx <= '0;
      r_addr_nxt <= BASE_ADDR;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (w_accept && (r_state == ST_HDR0)) r_hdr_hi <= byte_data;
      if (w_accept && (r_state == ST_HDR1)) r_word_cnt <= w_n;
      if (w_word_done) begin
        imem_we    <= 1'b1;
        imem_wdata <= w_word;
        imem_addr  <= r_addr_nxt;
        r_addr_nxt <= r_addr_nxt + 32'(WORD_BYTES);
        r_word_idx <= r_word_idx + 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over header and data bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xor <= '0;
    end else if (w_accept && ((r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                              (r_state == ST_DATA))) begin
      r_xor <= r_xor ^ byte_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (MAX_WORDS=4, BASE_ADDR=0).
// Covers both builds: checksum-only cases sit under IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_we, cpu_hold, done, error;
  logic [31:0] imem_addr, imem_wdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cyc = -1;
  int done_cyc = -1;
  int long_we = 0;
  logic prev_we = 1'b0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] words[$];

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      we_cyc <= cyc;
      if (prev_we) long_we <= long_we + 1;
    end
    if (done && (done_cyc < 0)) done_cyc <= cyc;
    prev_we <= imem_we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    we_cyc = -1;
    done_cyc = -1;
    long_we = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int g;
    g = 0;
    if (thr) begin
      while (($urandom_range(1, 0) == 0) && (g < 4)) begin
        byte_valid = 1'b0;
        @(negedge clk);
        g++;
      end
    end
    byte_valid = 1'b1;
    byte_data = b;
    g = 0;
    while (!byte_ready && (g < 20)) begin
      @(negedge clk);
      g++;
    end
    if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Sends count header and words; appends the correct XOR in checksum builds.
  task automatic send_image(input bit thr);
    logic [7:0]  x;
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(words.size());
    x = n[15:8] ^ n[7:0];
    send_byte(n[15:8], thr);
    send_byte(n[7:0], thr);
    foreach (words[i]) begin
      w = words[i];
      for (int j = 3; j >= 0; j--) begin
        send_byte(w[8*j +: 8], thr);
        x = x ^ w[8*j +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x, thr);
`endif
  endtask

  task automatic wait_end(input string tag);
    int g;
    g = 0;
    while (!done && !error && (g < 200)) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 32'(done | error), 32'd1);
  endtask

  task automatic check_writes();
    chk("wr_count", 32'(wr_addr.size()), 32'(words.size()));
    for (int i = 0; (i < words.size()) && (i < wr_addr.size()); i++) begin
      chk("wr_addr", wr_addr[i], 32'(4 * i));
      chk("wr_data", wr_data[i], words[i]);
    end
  endtask

  initial begin
    // Reset values, during and after reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    do_reset();
    chk("post_rst_ready", 32'(byte_ready), 32'd1);
    chk("post_rst_hold", 32'(cpu_hold), 32'd1);

    // Two-word reference image
    words = '{32'h2008_0005, 32'h0109_5020};
    send_image(1'b0);
    wait_end("img2_end");
    check_writes();
    chk("img2_done", 32'(done), 32'd1);
    chk("img2_error", 32'(error), 32'd0);
    chk("img2_hold", 32'(cpu_hold), 32'd0);
    repeat (2) @(negedge clk);
    chk("img2_ready", 32'(byte_ready), 32'd0);
    chk("img2_hold_addr", imem_addr, 32'h4);
    chk("img2_hold_data", imem_wdata, 32'h0109_5020);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("img2_done_lat", 32'(done_cyc - we_cyc), 32'd1);
`endif

    // Three-word image, unthrottled then throttled
    words = '{32'h1122_3344, 32'hDEAD_BEEF, 32'h0000_00FF};
    do_reset();
    send_image(1'b0);
    wait_end("img3_end");
    check_writes();
    chk("img3_pulse", 32'(long_we), 32'd0);
    do_reset();
    send_image(1'b1);
    wait_end("img3t_end");
    check_writes();
    chk("img3t_pulse", 32'(long_we), 32'd0);
    chk("img3t_done", 32'(done), 32'd1);

    // N == MAX_WORDS is accepted
    words = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF};
    do_reset();
    send_image(1'b0);
    wait_end("img4_end");
    check_writes();
    chk("img4_done", 32'(done), 32'd1);

    // N > MAX_WORDS goes straight to ERR
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_ready", 32'(byte_ready), 32'd0);
    chk("ovf_hold", 32'(cpu_hold), 32'd1);
    byte_valid = 1'b1;
    byte_data = 8'h12;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    chk("ovf_error_stay", 32'(error), 32'd1);
    chk("ovf_done", 32'(done), 32'd0);
    chk("ovf_writes", 32'(wr_addr.size()), 32'd0);

    // Empty image
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    repeat (2) @(negedge clk);
    chk("empty_wait_csum", 32'(done), 32'd0);
    send_byte(8'h00, 1'b0);
`endif
    wait_end("empty_end");
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_writes", 32'(wr_addr.size()), 32'd0);

    // Reset mid-load, then full resend
    words = '{32'h2008_0005, 32'h0109_5020};
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(imem_we), 32'd0);
    chk("abort_addr", imem_addr, 32'h0);
    chk("abort_wdata", imem_wdata, 32'h0);
    do_reset();
    chk("abort_done", 32'(done), 32'd0);
    send_image(1'b0);
    wait_end("resend_end");
    check_writes();
    chk("resend_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch on a one-word image
    words = '{32'hAABB_CCDD};
    do_reset();
    send_image(1'b0);
    wait_end("csum_ok_end");
    check_writes();
    chk("csum_ok_done", 32'(done), 32'd1);
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'h02, 1'b0);
    wait_end("csum_bad_end");
    check_writes();
    chk("csum_bad_error", 32'(error), 32'd1);
    chk("csum_bad_done", 32'(done), 32'd0);
    chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
